// File: rtl/fir_out_capture.sv
// Capture buffer for the FIR output stream: an arm-started window of DEPTH samples with
// an optional signed level trigger, peak tracking and a registered read-back port.
module fir_out_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH-1);

  state_t            state_reg;
  logic [DATA_W-1:0] trig_level_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic              trig_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign trig_hit = $signed(s_data) >= $signed(trig_level_reg);
  // arm wins over a coincident sample; in ARMED only a trigger-qualifying sample is stored
  assign wr_en    = !arm && s_valid &&
                    ((state_reg == CAPTURE) || ((state_reg == ARMED) && trig_hit));
  assign wr_addr  = count[ADDR_W-1:0];

  // Buffer has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      count          <= '0;
      peak_max       <= MOST_NEG;
      peak_min       <= MOST_POS;
      trig_level_reg <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_en && (state_reg == DONE)) begin
        rd_data  <= mem_reg[rd_addr];
        rd_valid <= 1'b1;
      end

      if (wr_en) begin
        if ($signed(s_data) > $signed(peak_max)) peak_max <= s_data;
        if ($signed(s_data) < $signed(peak_min)) peak_min <= s_data;
        count <= count + 1'b1;
      end

      if (arm) begin
        trig_level_reg <= trig_level;
        count          <= '0;
        peak_max       <= MOST_NEG;
        peak_min       <= MOST_POS;
        busy           <= 1'b1;
        done           <= 1'b0;
        state_reg      <= trig_en ? ARMED : CAPTURE;
      end else begin
        case (state_reg)
          ARMED: begin
            if (wr_en) state_reg <= CAPTURE;
          end
          CAPTURE: begin
            if (wr_en && (count == LAST_CNT)) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
